// File: rtl/jk_step_sequencer.sv
`default_nettype none
// ============================================================================
// jk_step_sequencer: drives J/K of an external JK bank as a mod-(MAX_VAL+1)
// up/down counter under a valid/ready command interface.      Rev 1.0
// ============================================================================
module jk_step_sequencer #(
    parameter int WIDTH   = 4,
    parameter int STEPW   = 8,
    parameter int MAX_VAL = 9
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [STEPW-1:0] CMD_ARG,
    input  logic [WIDTH-1:0] Q_FB,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             BUSY,
    output logic             DONE,
    output logic             WRAP
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [1:0] OP_UP   = 2'b00;
    localparam logic [1:0] OP_DOWN = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    localparam logic [WIDTH-1:0] C_MAX      = WIDTH'(MAX_VAL);
    localparam logic [STEPW-1:0] C_MAX_ARG  = STEPW'(MAX_VAL);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [STEPW-1:0] arg_q, arg_d;
    logic [STEPW-1:0] rem_q, rem_d;
    logic             wrap_q, wrap_d;
    logic [STEPW-1:0] accept_rem;
    logic [WIDTH-1:0] nxt_val;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            arg_q   <= '0;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
        end
    end

    // Target value the bank must take at the next edge; every bit is forced.
    always_comb begin
        nxt_val = '0;
        case (op_q)
            OP_UP:   nxt_val = (Q_FB >= C_MAX) ? '0 : Q_FB + WIDTH'(1);
            OP_DOWN: nxt_val = ((Q_FB == '0) || (Q_FB > C_MAX)) ? C_MAX : Q_FB - WIDTH'(1);
            OP_LOAD: nxt_val = (arg_q > C_MAX_ARG) ? C_MAX : arg_q[WIDTH-1:0];
            default: nxt_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        arg_d      = arg_q;
        rem_d      = rem_q;
        wrap_d     = 1'b0;
        accept_rem = CMD_OP[1] ? STEPW'(1) : CMD_ARG;
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    op_d    = CMD_OP;
                    arg_d   = CMD_ARG;
                    rem_d   = accept_rem;
                    state_d = (accept_rem != '0) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                rem_d  = rem_q - STEPW'(1);
                wrap_d = ((op_q == OP_UP) && (Q_FB >= C_MAX)) ||
                         ((op_q == OP_DOWN) && (Q_FB == '0));
                if (rem_q <= STEPW'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        CMD_READY = (state_q == S_IDLE) && !RESET;
        BUSY      = (state_q != S_IDLE);
        DONE      = (state_q == S_FIN);
        J         = '0;
        K         = '0;
        if (state_q == S_RUN) begin
            J = nxt_val;
            K = ~nxt_val;
        end
    end

    assign WRAP = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_step_sequencer.sv
`default_nettype none
// ============================================================================
// tb_jk_step_sequencer: JK bank model plus reference counter model driving
// directed and random commands into jk_step_sequencer.        Rev 1.0
// ============================================================================
module tb_jk_step_sequencer;

    localparam int WIDTH   = 4;
    localparam int STEPW   = 8;
    localparam int MAX_VAL = 9;
    localparam int MASK    = (1 << WIDTH) - 1;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [STEPW-1:0] CMD_ARG;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             BUSY;
    logic             DONE;
    logic             WRAP;
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] ovr_val;
    logic             ovr_en;

    int n_cmp = 0;
    int n_err = 0;
    int model_v = 0;

    jk_step_sequencer #(.WIDTH(WIDTH), .STEPW(STEPW), .MAX_VAL(MAX_VAL)) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_ARG   (CMD_ARG),
        .Q_FB      (q_fb),
        .J         (J),
        .K         (K),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .WRAP      (WRAP)
    );

    always #5 CLK = ~CLK;

    // External JK flip-flop bank sharing clock and reset with the sequencer.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) bank_q <= '0;
        else       bank_q <= (J & ~bank_q) | (~K & bank_q);
    end

    assign q_fb = ovr_en ? ovr_val : bank_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counter semantics: one step of the modulo-(MAX_VAL+1) counter.
    function automatic int ref_step(input int v, input int op, input int arg, output bit wr);
        wr = 1'b0;
        case (op)
            0: begin
                if (v >= MAX_VAL) begin wr = 1'b1; return 0; end
                return v + 1;
            end
            1: begin
                if (v == 0) begin wr = 1'b1; return MAX_VAL; end
                if (v > MAX_VAL) return MAX_VAL;
                return v - 1;
            end
            2: return (arg > MAX_VAL) ? MAX_VAL : arg;
            default: return 0;
        endcase
    endfunction

    task automatic do_cmd(input int op, input int arg, input bit hold);
        int n;
        int nv;
        bit wr;
        n = (op < 2) ? arg : 1;
        @(negedge CLK);
        check("ready_idle", 32'(CMD_READY), 32'd1);
        CMD_VALID = 1'b1;
        CMD_OP    = op[1:0];
        CMD_ARG   = arg[STEPW-1:0];
        @(posedge CLK); #1;
        if (hold) begin
            CMD_OP  = 2'($urandom);
            CMD_ARG = STEPW'($urandom);
        end else begin
            CMD_VALID = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            nv = ref_step(model_v, op, arg, wr);
            check("busy_run", 32'(BUSY), 32'd1);
            check("ready_run", 32'(CMD_READY), 32'd0);
            check("done_run", 32'(DONE), 32'd0);
            check("j_run", 32'(J), 32'(nv));
            check("k_run", 32'(K), 32'((~nv) & MASK));
            @(posedge CLK); #1;
            check("q_step", 32'(bank_q), 32'(nv));
            check("wrap_step", 32'(WRAP), 32'(wr));
            model_v = nv;
        end
        check("done_fin", 32'(DONE), 32'd1);
        check("busy_fin", 32'(BUSY), 32'd1);
        check("jk_fin", 32'({J, K}), 32'd0);
        CMD_VALID = 1'b0;
        @(posedge CLK); #1;
        check("done_clear", 32'(DONE), 32'd0);
        check("ready_back", 32'(CMD_READY), 32'd1);
        check("wrap_idle", 32'(WRAP), 32'd0);
        check("q_hold", 32'(bank_q), 32'(model_v));
    endtask

    // Single step with the feedback forced out of range.
    task automatic do_ovr(input int op, input int fb, input int exp_nxt, input bit exp_wr);
        @(negedge CLK);
        ovr_en    = 1'b1;
        ovr_val   = fb[WIDTH-1:0];
        CMD_VALID = 1'b1;
        CMD_OP    = op[1:0];
        CMD_ARG   = 8'd1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        check("j_ovr", 32'(J), 32'(exp_nxt));
        check("k_ovr", 32'(K), 32'((~exp_nxt) & MASK));
        @(posedge CLK); #1;
        check("wrap_ovr", 32'(WRAP), 32'(exp_wr));
        check("done_ovr", 32'(DONE), 32'd1);
        ovr_en = 1'b0;
        @(posedge CLK); #1;
        check("q_ovr", 32'(bank_q), 32'(exp_nxt));
        model_v = exp_nxt;
    endtask

    initial begin
        int dones;
        int op;
        int arg;
        RESET     = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'd0;
        CMD_ARG   = '0;
        ovr_en    = 1'b0;
        ovr_val   = '0;
        repeat (2) @(negedge CLK);
        check("ready_in_reset", 32'(CMD_READY), 32'd0);
        check("busy_in_reset", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("ready_after_reset", 32'(CMD_READY), 32'd1);
        check("busy_after_reset", 32'(BUSY), 32'd0);
        check("jk_after_reset", 32'({J, K}), 32'd0);
        check("bank_after_reset", 32'(bank_q), 32'd0);
        model_v = 0;

        do_cmd(0, 3, 1'b0);
        do_cmd(2, 8, 1'b0);
        do_cmd(0, 2, 1'b0);
        do_cmd(1, 1, 1'b0);
        do_cmd(2, 12, 1'b0);
        do_cmd(2, 5, 1'b0);
        do_cmd(3, 0, 1'b0);
        do_cmd(0, 0, 1'b0);
        do_cmd(0, 4, 1'b1);
        do_cmd(1, 0, 1'b1);
        do_cmd(0, 255, 1'b0);

        do_ovr(0, 12, 0, 1'b1);
        do_ovr(1, 13, MAX_VAL, 1'b0);

        // Abort an up-10 mid-flight.
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_OP    = 2'd0;
        CMD_ARG   = 8'd10;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        check("abort_jk", 32'({J, K}), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_wrap", 32'(WRAP), 32'd0);
        check("abort_ready", 32'(CMD_READY), 32'd0);
        check("abort_bank", 32'(bank_q), 32'd0);
        @(negedge CLK);
        RESET   = 1'b0;
        model_v = 0;
        dones   = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        do_cmd(0, 2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op  = int'($urandom_range(0, 3));
            arg = (op < 2) ? int'($urandom_range(0, 25)) : int'($urandom_range(0, 255));
            do_cmd(op, arg, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jk_step_sequencer.md
Name: jk_step_sequencer

Overview:
Excitation and sequencing stage that drives the J/K inputs of an external bank of WIDTH JK flip-flops. It reads the bank's Q back as feedback. The block accepts commands over a valid/ready handshake: count up N steps, count down N steps, load, or clear. It then drives the per-bit J/K pairs cycle by cycle so the bank behaves as a modulo-(MAX_VAL+1) up/down counter. The bank and this block share CLK and RESET.

Parameters:
WIDTH, 4, number of JK flip-flops in the driven bank
STEPW, 8, width of CMD_ARG (step count or load value)
MAX_VAL, 9, highest count value; wrap point (must be <= 2**WIDTH-1)

Ports:
CLK  input  1  clock; all state changes on the rising edge
RESET  input  1  asynchronous, active-high reset
CMD_VALID  input  1  command present
CMD_READY  output  1  block can accept a command
CMD_OP  input  2  00 up, 01 down, 10 load, 11 clear
CMD_ARG  input  STEPW  step count (up/down) or load value (load); ignored for clear
Q_FB  input  WIDTH  current Q of the JK bank
J  output  WIDTH  J drive to the bank
K  output  WIDTH  K drive to the bank
BUSY  output  1  command in progress (state != IDLE)
DONE  output  1  one-cycle pulse when a command completes
WRAP  output  1  one-cycle pulse after a wrapping step

Behaviour:
- Reset (async, any time, including mid-command):
  - state -> IDLE; internal counters cleared.
  - J=K=0, BUSY=0, DONE=0, WRAP=0, CMD_READY=0 while RESET is high.
  - An aborted command produces no DONE.
- States: IDLE, RUN, FIN.
- IDLE:
  - CMD_READY=1, J=K=0.
  - An edge with CMD_VALID&CMD_READY accepts the command and latches op and arg.
  - Remaining count rem: CMD_ARG for up/down, 1 for load/clear.
  - Next state: RUN if rem!=0, else FIN (zero-step up/down completes with no drive).
- RUN:
  - CMD_READY=0, BUSY=1.
  - J/K are combinational from the latched op and Q_FB.
  - Every edge decrements rem; the edge where rem==1 moves to FIN.
  - up: nxt = (Q_FB>=MAX_VAL) ? 0 : Q_FB+1.
  - down: nxt = (Q_FB==0 || Q_FB>MAX_VAL) ? MAX_VAL : Q_FB-1.
  - load: nxt = min(CMD_ARG[latched], MAX_VAL); upper arg bits are compared, not truncated.
  - clear: nxt = 0.
  - Drive J=nxt, K=~nxt (all bits forced; no toggle code is used).
- FIN: J=K=0, DONE=1 for exactly one cycle, CMD_READY=0, next state IDLE.
- Timing for an N-step command accepted at edge e0:
  - The bank updates at edges e1..eN.
  - DONE is high between eN and eN+1.
  - CMD_READY returns after eN+1.
  - Occupancy is N+2 cycles; load/clear take 3 cycles.
- WRAP is registered. It is high for the one cycle after an edge at which a RUN up step had Q_FB>=MAX_VAL, or a down step had Q_FB==0. Load and clear never wrap.
- Q_FB out of range (>MAX_VAL): up goes to 0 with WRAP; down goes to MAX_VAL without WRAP.
- CMD_VALID while not ready is ignored. CMD_OP and CMD_ARG are sampled only at the accept edge; later changes have no effect.
- The step counter is STEPW bits; CMD_ARG = 2**STEPW-1 is legal.

Test Plan:
- RESET pulse, then idle → J=K=0, CMD_READY=1, BUSY=0; bank Q=0.
- Up 3 from Q=0 (MAX_VAL=9) → Q=1,2,3 on successive edges; DONE one cycle after the third edge; no WRAP; ready 5 cycles after accept.
- Up 2 from Q=8 → Q=9 then 0; WRAP pulses once after the 9→0 edge; DONE follows. Then down 1 from Q=0 → Q=9 with WRAP.
- Load arg=12 → Q=9 (clamped). Load arg=5 → Q=5, J=0101, K=1010 during RUN. Clear → Q=0, K=1111. Each command takes 3 cycles.
- Up 0 → no J/K activity, Q unchanged, DONE in the cycle after accept. CMD_VALID held during BUSY with a changing CMD_ARG → only the accepted command executes.
- RESET asserted mid-way through an up-10 → outputs clear immediately, no DONE, bank Q=0; the next command is accepted normally.
